// File: rtl/inst_fetch_buffer_pkg.sv
// Shared CPU defines for the instruction fetch buffer: word width, reset vector,
// fetch-control state encoding and the buffered entry layout.
package inst_fetch_buffer_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  function automatic word_t next_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Fetch buffer bus bundle: pipeline redirect, icache request/response and decode handshake.
// master = fetch buffer side, slave = icache/pipeline/decode side.
interface inst_fetch_buffer_if;
  import inst_fetch_buffer_pkg::*;

  logic  flush;
  word_t flush_pc;
  word_t s_araddr;
  logic  s_arvalid;
  word_t s_rdata;
  logic  s_rvalid;
  logic  id_valid;
  logic  id_ready;
  word_t id_pc;
  word_t id_inst;

  modport master (
    input  flush, flush_pc, s_rdata, s_rvalid, id_ready,
    output s_araddr, s_arvalid, id_valid, id_pc, id_inst
  );

  modport slave (
    output flush, flush_pc, s_rdata, s_rvalid, id_ready,
    input  s_araddr, s_arvalid, id_valid, id_pc, id_inst
  );

endinterface

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// fetch_fifo: circular buffer of {pc, inst} entries with push/pop/clear.
// Pointers wrap modulo DEPTH; count carries one extra bit to tell full from empty.
module fetch_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            full;

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (push && !clear && (wr_ptr_q == PW'(i))) ? wdata : mem_q[i];
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1'b1);
        2'b01:   count_d = count_q - (PW+1)'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  fetch_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: rtl/inst_fetch_buffer_fifo_chk.sv
// Protocol checker for fetch_fifo: the issue rule must never let a push land in a
// full FIFO, and pops are only legal while entries exist.
module fetch_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic clear,
  input logic full,
  input logic empty
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && !clear && full))
    else $error("fetch_fifo: push into full FIFO");

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !clear && empty))
    else $error("fetch_fifo: pop from empty FIFO");

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: single-outstanding icache fetch control, redirect handling
// and a decode-side FIFO. Optional macro FETCH_BUF_BYPASS_EN forwards a response
// straight to decode when the FIFO is empty.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int    FIFO_DEPTH = 4,
  parameter word_t RESET_PC   = RESET_PC_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  inst_fetch_buffer_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_fetch_buffer: FIFO_DEPTH must be a power of two, at least 2");
  end

  fetch_state_e  state_q, state_d;
  word_t         pc_q, pc_d;
  word_t         araddr_q, araddr_d;
  logic          issue;
  logic          rsp_accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [PW:0]   fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  rsp_entry;

  // Fetch FSM: issue decision, response acceptance/drop and PC redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    araddr_d   = araddr_q;
    issue      = 1'b0;
    rsp_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          pc_d = bus.flush_pc;
        end else if (rst && !bus.s_rvalid && (fifo_count < DEPTH_C)) begin
          issue    = 1'b1;
          araddr_d = pc_q;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.s_rvalid) begin
          state_d = ST_IDLE;
          if (bus.flush) begin
            pc_d = bus.flush_pc;
          end else begin
            rsp_accept = 1'b1;
            pc_d       = next_pc(pc_q);
          end
        end else if (bus.flush) begin
          state_d = ST_DISCARD;
          pc_d    = bus.flush_pc;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        pc_d    = bus.flush ? bus.flush_pc : pc_q;
        state_d = bus.s_rvalid ? ST_IDLE : ST_DISCARD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      araddr_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      araddr_q <= araddr_d;
    end
  end

  // Address is the live PC while idle, then held until the response returns.
  assign bus.s_araddr  = (state_q == ST_IDLE) ? pc_q : araddr_q;
  assign bus.s_arvalid = issue;
  assign rsp_entry     = '{pc: araddr_q, inst: bus.s_rdata};
  assign pop           = !fifo_empty && bus.id_ready && !bus.flush;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass;
  assign bypass       = fifo_empty && rsp_accept;
  assign push         = rsp_accept && !(bypass && bus.id_ready);
  assign bus.id_valid = !fifo_empty || bypass;
  assign bus.id_pc    = bypass ? rsp_entry.pc   : head.pc;
  assign bus.id_inst  = bypass ? rsp_entry.inst : head.inst;
`else
  assign push         = rsp_accept;
  assign bus.id_valid = !fifo_empty;
  assign bus.id_pc    = head.pc;
  assign bus.id_inst  = head.inst;
`endif

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .clear (bus.flush),
    .wdata (rsp_entry),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction entries buffered between the icache and decode; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'hBFC00000, first fetch address after reset.
REQ-003 Port clk  in  1  sole clock, all state updates on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port flush  in  1  redirect request from the pipeline (branch, exception, eret).
REQ-006 Port flush_pc  in  32  redirect target, sampled when flush=1.
REQ-007 Port s_araddr  out  32  fetch address to icache; held stable from issue until the matching s_rvalid.
REQ-008 Port s_arvalid  out  1  one-cycle issue pulse to icache.
REQ-009 Port s_rdata  in  32  instruction word from icache.
REQ-010 Port s_rvalid  in  1  one-cycle response strobe from icache.
REQ-011 Port id_valid  out  1  FIFO head valid toward decode.
REQ-012 Port id_ready  in  1  decode accepts the head this cycle.
REQ-013 Port id_pc  out  32  PC of the head entry.
REQ-014 Port id_inst  out  32  instruction of the head entry.

Function
REQ-015 At most one icache request outstanding; inflight flag set on issue, cleared on s_rvalid.
REQ-016 Issue s_arvalid=1 when inflight=0, no response is accepted in the same cycle, and (count + pending) < FIFO_DEPTH; otherwise s_arvalid=0.
REQ-017 On issue, s_araddr=pc; pc advances by 4 when the non-discarded response is accepted.
REQ-018 Non-discarded s_rvalid pushes {s_araddr, s_rdata} at the FIFO tail; issue rule guarantees no overflow; a push into a full FIFO is an assertion failure.
REQ-019 id_valid=1 iff count>0; a pop occurs when id_valid and id_ready are both 1; simultaneous push and pop leaves count unchanged.
REQ-020 FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
REQ-021 Control FSM states: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (outstanding response to be dropped).
REQ-022 Transitions: IDLE->WAIT on issue; WAIT->IDLE on s_rvalid; WAIT->DISCARD on flush without s_rvalid; DISCARD->IDLE on s_rvalid, dropping that data.
REQ-023 On flush: FIFO emptied (count=0, pointers 0) in the same edge, pc<=flush_pc, id_valid=0 next cycle, and any pop that cycle is ignored.
REQ-024 Flush coincident with s_rvalid: the response is dropped, FSM->IDLE, and the next issue (flush_pc) may occur the following cycle.
REQ-025 Flush while in DISCARD: pc updated to the newest flush_pc, state remains DISCARD.
REQ-026 Flush-to-first-issue latency: 1 cycle from IDLE; from WAIT/DISCARD, 1 cycle after the dropped s_rvalid.

Reset
REQ-027 While rst=0: s_arvalid=0, s_araddr=RESET_PC, id_valid=0, id_pc=0, id_inst=0, pc=RESET_PC, count=0, FSM=IDLE.
REQ-028 Reset asserted mid-request abandons the request; no discard is owed, and the icache is reset by the same rst.
REQ-029 First issue occurs on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro FETCH_BUF_BYPASS_EN: when defined and count=0 with an accepted non-discarded s_rvalid, id_valid=1 combinationally with id_pc/id_inst from the response; if id_ready=1 that cycle, no push occurs.
REQ-031 Without FETCH_BUF_BYPASS_EN, every instruction passes through the FIFO; minimum response-to-id_valid latency is 1 cycle.

Structure
REQ-032 RESET_PC default, the 32-bit word/address width, and the FSM state encodings belong in the shared CPU defines package.
REQ-033 A single sub-module, fetch_fifo, holds the storage, pointers, and count with push/pop/clear ports; the FSM and PC logic remain in the top level.

Verification
REQ-034 Reset then 8 responses with 1-cycle icache latency and id_ready=1 -> id_pc 0xBFC00000..0xBFC0001C in order, with no gaps beyond the icache latency.
REQ-035 id_ready=0 with FIFO_DEPTH=4 -> exactly 4 issues, then s_arvalid stays 0; after id_ready=1, issuing resumes at 0xBFC00010.
REQ-036 Flush (flush_pc=0x80000100) while in WAIT -> the next s_rvalid is dropped, then s_araddr=0x80000100 is issued, and id_pc=0x80000100 is the first entry after the flush.
REQ-037 Flush coincident with s_rvalid and a pop -> count=0 next cycle, the dropped word never appears on id_inst, and an issue to flush_pc occurs the next cycle.
REQ-038 With FETCH_BUF_BYPASS_EN, empty FIFO, id_ready=1, and s_rvalid carrying 0x24080001 -> id_valid=1 and id_inst=0x24080001 in the same cycle, with count staying 0.
REQ-039 rst pulsed low mid-WAIT -> all outputs at their reset values immediately, and the first issue after deassertion is to 0xBFC00000.
